mac8_acc_ctrl: RTL and testbench

- Accumulator/control stage directly downstream of reversible_16bit_adder in the MAC8 datapath.
- Consumes a stream of 16-bit products and feeds the running accumulator back as adder operand A, with the product as operand B and Cin=0.
- Registers Sum/Carry into the accumulator and tracks overflow.
- After a programmed number of beats, presents the result on a valid/ready output port.

---
 rtl/mac8_pkg.sv | 15 +
 rtl/reversible_16bit_adder.sv | 23 ++
 rtl/mac8_acc_ctrl.sv | 108 ++++++++++
 tb/tb_mac8_acc_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac8_pkg.sv
// Shared constants and state encoding for the MAC8 accumulate/control stage.
package mac8_pkg;

   localparam int ACC_W = 16;
   localparam int CNT_W = 8;

   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } acc_state_t;

endpackage

// File: rtl/reversible_16bit_adder.sv
// 16-bit ripple adder built from Peres-gate style full-adder cells (sum = a^b^c,
// carry = ab ^ (a^b)c), purely combinational.
module reversible_16bit_adder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        carry
);

   always_comb begin
      logic [16:0] c;
      c     = '0;
      sum   = '0;
      c[0]  = cin;
      for (int i = 0; i < 16; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) ^ ((a[i] ^ b[i]) & c[i]);
      end
      carry = c[16];
   end

endmodule

// File: rtl/mac8_acc_ctrl.sv
// MAC8 accumulator/control stage: sums a programmed number of product beats
// through the reversible adder and hands the result out on a valid/ready port.
module mac8_acc_ctrl
   import mac8_pkg::*;
#(
   parameter int ACC_W    = mac8_pkg::ACC_W,
   parameter int CNT_W    = mac8_pkg::CNT_W,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [ACC_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);

   acc_state_t       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_q;
   logic             ovf;

   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [ACC_W-1:0] acc_next;
   logic             ovf_next;
   logic             last_beat;

   reversible_16bit_adder u_adder (
      .a     (acc),
      .b     (in_data),
      .cin   (1'b0),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // Once clamped to all-ones, any nonzero beat carries again, so saturation sticks.
   always_comb begin
      acc_next  = (add_carry && SATURATE) ? ACC_MAX : add_sum;
      ovf_next  = ovf | add_carry;
      last_beat = (cnt == len_q - CNT_W'(1));
   end

   assign in_ready = (state == ACCUM);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         len_q     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  len_q <= len;
                  if (len == '0) begin
                     state     <= OUTPUT;
                     out_valid <= 1'b1;
                     out_acc   <= '0;
                     out_ovf   <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc <= acc_next;
                  ovf <= ovf_next;
                  // The result register loads on the same edge as the final beat.
                  if (last_beat) begin
                     state     <= OUTPUT;
                     out_valid <= 1'b1;
                     out_acc   <= acc_next;
                     out_ovf   <= ovf_next;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac8_acc_ctrl.sv
// Scoreboard bench for mac8_acc_ctrl: a saturating and a wrapping instance share
// one stimulus stream and are checked against an integer-sum reference model.
module tb_mac8_acc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;

   logic        in_ready_s, out_valid_s, out_ovf_s, busy_s;
   logic [15:0] out_acc_s;
   logic        in_ready_w, out_valid_w, out_ovf_w, busy_w;
   logic [15:0] out_acc_w;

   typedef struct {
      logic [15:0] acc;
      logic        ovf;
   } exp_t;

   exp_t q_sat[$];
   exp_t q_wrap[$];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mac8_acc_ctrl #(.SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_acc(out_acc_s), .out_ovf(out_ovf_s), .busy(busy_s)
   );

   mac8_acc_ctrl #(.SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
      .out_valid(out_valid_w), .out_ready(out_ready),
      .out_acc(out_acc_w), .out_ovf(out_ovf_w), .busy(busy_w)
   );

   function automatic void checkOutput(input string name, input logic [31:0] act,
                                       input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endfunction

   // Any carry means the true integer total exceeded 16 bits; saturation then pins at all-ones.
   function automatic void pushExpected(input logic [15:0] beats[$]);
      longint total = 0;
      logic   over;
      foreach (beats[i]) total += longint'(beats[i]);
      over = (total > 64'd65535);
      q_wrap.push_back('{acc: total[15:0], ovf: over});
      q_sat.push_back('{acc: over ? 16'hFFFF : total[15:0], ovf: over});
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid_s) begin
            if (q_sat.size() == 0) checkOutput("sat_unexpected_valid", out_valid_s, 0);
            else begin
               checkOutput("sat_acc", out_acc_s, q_sat[0].acc);
               checkOutput("sat_ovf", out_ovf_s, q_sat[0].ovf);
               if (out_ready) void'(q_sat.pop_front());
            end
         end
         if (out_valid_w) begin
            if (q_wrap.size() == 0) checkOutput("wrap_unexpected_valid", out_valid_w, 0);
            else begin
               checkOutput("wrap_acc", out_acc_w, q_wrap[0].acc);
               checkOutput("wrap_ovf", out_ovf_w, q_wrap[0].ovf);
               if (out_ready) void'(q_wrap.pop_front());
            end
         end
      end
   end

   task automatic waitIdle();
      int budget = 50;
      while ((busy_s || busy_w) && budget > 0) begin
         @(posedge clk) #1;
         budget--;
      end
      if (budget == 0) checkOutput("wait_idle_timeout", busy_s, 0);
   endtask

   task automatic applyStimulus(input int n, input logic [15:0] beats[$], input int gap,
                                input int bp, input bit start_in_out);
      waitIdle();
      pushExpected(beats);
      out_ready = (bp == 0);
      start     = 1'b1;
      len       = n[7:0];
      @(posedge clk) #1;
      start = 1'b0;
      if (n == 0) begin
         checkOutput("zero_len_valid", out_valid_s, 1);
         checkOutput("zero_len_in_ready", in_ready_s, 0);
      end else begin
         checkOutput("accum_in_ready", in_ready_s, 1);
         for (int i = 0; i < beats.size(); i++) begin
            if (i != 0) begin
               repeat (gap) begin
                  in_valid = 1'b0;
                  in_data  = 16'($urandom);
                  @(posedge clk) #1;
               end
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            @(posedge clk) #1;
         end
         in_valid = 1'b0;
         checkOutput("latency_sat_valid", out_valid_s, 1);
         checkOutput("latency_wrap_valid", out_valid_w, 1);
         checkOutput("output_in_ready", in_ready_s, 0);
      end
      repeat (bp) begin
         if (start_in_out) begin
            start = 1'b1;
            len   = 8'd7;
         end
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         @(posedge clk) #1;
         checkOutput("held_busy", busy_s, 1);
         checkOutput("held_valid", out_valid_s, 1);
         checkOutput("held_in_ready", in_ready_s, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      start     = start_in_out;
      @(posedge clk) #1;
      start = 1'b0;
      checkOutput("idle_after_hs_busy", busy_s, 0);
      checkOutput("idle_after_hs_valid", out_valid_s, 0);
      checkOutput("idle_after_hs_busy_w", busy_w, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] bq[$];
      int          n;
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", busy_s, 0);
      checkOutput("reset_in_ready", in_ready_s, 0);
      checkOutput("reset_out_valid", out_valid_s, 0);
      checkOutput("reset_out_acc", out_acc_s, 16'h0000);
      checkOutput("reset_out_ovf", out_ovf_s, 0);
      rst = 1'b0;

      // Abort an accumulation part-way; its result must never appear.
      bq = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
      pushExpected(bq);
      start = 1'b1;
      len   = 8'd4;
      @(posedge clk) #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = bq[i];
         @(posedge clk) #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk) #1;
      checkOutput("midrst_busy", busy_s, 0);
      checkOutput("midrst_in_ready", in_ready_s, 0);
      checkOutput("midrst_out_valid", out_valid_s, 0);
      void'(q_sat.pop_back());
      void'(q_wrap.pop_back());
      rst = 1'b0;
      bq = {16'h0005};
      applyStimulus(1, bq, 0, 0, 1'b0);

      bq = {16'h0010, 16'h0020, 16'h0030, 16'h0040};
      applyStimulus(4, bq, 0, 0, 1'b0);
      bq = {16'hFFF0, 16'h0020, 16'h0001};
      applyStimulus(3, bq, 0, 0, 1'b0);
      bq = {16'hFFFF, 16'h0000};
      applyStimulus(2, bq, 1, 1, 1'b0);
      bq = {16'h1234, 16'h0001};
      applyStimulus(2, bq, 2, 5, 1'b1);
      bq = {};
      applyStimulus(0, bq, 0, 2, 1'b1);

      bq = {};
      for (int i = 0; i < 255; i++) bq.push_back(16'h0001);
      applyStimulus(255, bq, 0, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
         bq = {};
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
               0:       bq.push_back(16'($urandom_range(0, 255)));
               1:       bq.push_back(16'hFFFF);
               default: bq.push_back(16'($urandom_range(0, 65535)));
            endcase
         end
         applyStimulus(n, bq, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
      end

      waitIdle();
      checkOutput("sat_queue_drained", q_sat.size(), 0);
      checkOutput("wrap_queue_drained", q_wrap.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
